ro_freq_meter: RTL and testbench
================================

Name: ro_freq_meter

Overview:
Downstream measurement stage for the ring-oscillator buffer output. It takes one selected RO signal, which is asynchronous to clk, and synchronises it. It counts rising edges over a programmable gate window of clk cycles and latches the result as a frequency count. The result can be read as a full word or one byte at a time through the 8-bit output bus of the TT wrapper.

Parameters:
CNT_W, 16, width of edge accumulator and latched count (>=4)
GATE_W, 16, width of gate-length input and gate down-counter
SYNC_STAGES, 2, synchroniser flop depth for ro_in (>=2)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
ro_in  input  1  ring-oscillator signal, asynchronous to clk
start  input  1  synchronous; rising edge requests a measurement
gate_len  input  GATE_W  window length in clk cycles; sampled on accepted start
byte_sel  input  1  0 = count[7:0], 1 = count[15:8] on count_byte
busy  output  1  high while in MEASURE
done  output  1  one-cycle pulse when count/ovf update
ovf  output  1  accumulator saturated during last window
count  output  CNT_W  last completed measurement
count_byte  output  8  byte of count chosen by byte_sel (zero-extended if CNT_W<16)

Behaviour:
- Reset (asynchronous, active-low): state=IDLE. busy, done, ovf, count, gate counter, accumulator and all sync/edge flops go to 0. count_byte=0.
- The clock is clk and the reset is rst_n. There is one clock domain, and rst_n is asserted asynchronously.
- ro_in path: SYNC_STAGES flop chain, then one prev flop. edge = sync_out & ~prev.
  - Valid only for RO frequency < clk/2. Higher rates alias; this is documented and not detected.
- start_q flop. start_rise = start & ~start_q.
- States: IDLE, MEASURE, DONE.
- IDLE/DONE + start_rise:
  - gate_len != 0: load gate_cnt = gate_len, clear acc, go to MEASURE next cycle.
  - gate_len == 0: go to DONE next cycle with count=0, ovf=0 and a done pulse.
- MEASURE: exactly gate_len consecutive cycles. Each cycle:
  - edge increments acc; acc saturates at 2^CNT_W-1 and sets an internal ovf flag.
  - gate_cnt decrements.
  - On the cycle gate_cnt==1, the edge from that cycle is included. Then count <= final acc, ovf <= flag, go to DONE.
- DONE: done=1 for the first DONE cycle only. count/ovf hold until the next measurement completes; they are not cleared at start.
- start_rise during MEASURE is ignored. gate_len changes during MEASURE are ignored.
- Edges outside MEASURE are never counted.
- busy = (state==MEASURE).
- count_byte: combinational mux of the registered count.
- Reset mid-MEASURE: aborts immediately, and all outputs return to reset values.

Optional Feature:
- Macro: RO_FREQ_CONT_EN.
- Defined: continuous mode. In the DONE cycle, if start is still high, the block reloads gate_cnt from the previously latched gate_len and re-enters MEASURE on the next cycle. done then pulses once every gate_len+1 cycles. When start is low in DONE, the block stays in DONE.
- Undefined: every measurement requires a new start rising edge. The latched-gate register is not built.

Test Plan:
1. Reset with ro_in toggling -> busy=0, done=0, ovf=0, count=0, count_byte=0. Nothing changes until start.
2. ro_in period 8 clk (4 high / 4 low) running 20 cycles before start; gate_len=80, start pulse -> busy for 80 cycles, then done for 1 cycle, count=10, ovf=0.
3. CNT_W=4, ro_in period 4, gate_len=100 -> count=15, ovf=1. A second run with gate_len=20 -> count=5, ovf=0.
4. gate_len=0, start rise -> DONE next cycle, done for 1 cycle, count=0, busy never high.
5. ro_in period 2, gate_len=9320 -> count=0x1234; byte_sel=0 -> count_byte=0x34, byte_sel=1 -> count_byte=0x12. Re-pulse start mid-window -> ignored, result unchanged. Assert rst_n low mid-window -> IDLE, count=0.
6. With RO_FREQ_CONT_EN, ro_in period 8, gate_len=40, start held high -> done every 41 cycles, count=5 each time. Drop start -> stays in DONE.

Source files
------------

// File: rtl/ro_freq_meter.sv
// ro_freq_meter
//
// Purpose:
//   Measures the frequency of one ring-oscillator signal that is asynchronous
//   to clk. The signal is synchronised, its rising edges are counted over a
//   programmable window of clk cycles, and the result is latched as a
//   frequency count. The count is readable as a full word or one byte at a
//   time through the 8-bit TT wrapper bus.
//
// Configuration macro:
//   RO_FREQ_CONT_EN - when defined, holding start high re-arms the window
//                     from the last accepted gate length (continuous mode).
//                     When undefined, every measurement needs a fresh
//                     rising edge on start and no gate-length latch exists.
//
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   ro_in       ring-oscillator input, asynchronous to clk
//   start       rising edge requests a measurement
//   gate_len    window length in clk cycles, sampled on an accepted start
//   byte_sel    0 selects count[7:0], 1 selects count[15:8] on count_byte
//   busy        high while a window is open
//   done        one-cycle pulse when count/ovf are updated
//   ovf         the accumulator saturated during the last window
//   count       result of the last completed measurement
//   count_byte  selected byte of count (zero-extended when CNT_W < 16)
//
// Edge detection is only meaningful for RO frequencies below clk/2; faster
// signals alias in the synchroniser and this is not detected.

module ro_freq_meter #(
  parameter int CNT_W       = 16,
  parameter int GATE_W      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ro_in,
  input  logic              start,
  input  logic [GATE_W-1:0] gate_len,
  input  logic              byte_sel,
  output logic              busy,
  output logic              done,
  output logic              ovf,
  output logic [CNT_W-1:0]  count,
  output logic [7:0]        count_byte
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_MEASURE = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [SYNC_STAGES-1:0] sync_ff;
  logic                   ro_prev;
  logic                   ro_edge;
  logic                   start_q;
  logic                   start_rise;

  logic [GATE_W-1:0]      gate_cnt;
  logic [GATE_W-1:0]      gate_cnt_nxt;
  logic [CNT_W-1:0]       acc;
  logic [CNT_W-1:0]       acc_nxt;
  logic                   ovf_flag;
  logic                   ovf_flag_nxt;
  logic [CNT_W-1:0]       count_nxt;
  logic                   ovf_nxt;
  logic                   done_nxt;

`ifdef RO_FREQ_CONT_EN
  logic [GATE_W-1:0]      gate_lat;
  logic [GATE_W-1:0]      gate_lat_nxt;
`endif

  // Synchroniser chain for ro_in followed by one history flop, so an edge is
  // detected on the fully synchronised value. start gets its own history
  // flop for rising-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_ff <= '0;
      ro_prev <= 1'b0;
      start_q <= 1'b0;
    end else begin
      sync_ff <= {sync_ff[SYNC_STAGES-2:0], ro_in};
      ro_prev <= sync_ff[SYNC_STAGES-1];
      start_q <= start;
    end
  end

  assign ro_edge    = sync_ff[SYNC_STAGES-1] & ~ro_prev;
  assign start_rise = start & ~start_q;

  // State, window counter, accumulator and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      gate_cnt <= '0;
      acc      <= '0;
      ovf_flag <= 1'b0;
      count    <= '0;
      ovf      <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      gate_cnt <= gate_cnt_nxt;
      acc      <= acc_nxt;
      ovf_flag <= ovf_flag_nxt;
      count    <= count_nxt;
      ovf      <= ovf_nxt;
      done     <= done_nxt;
    end
  end

`ifdef RO_FREQ_CONT_EN
  // Remembers the gate length of the last accepted start so continuous mode
  // can re-arm without a new start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gate_lat <= '0;
    end else begin
      gate_lat <= gate_lat_nxt;
    end
  end
`endif

  // Next-state and datapath logic. A zero-length request completes at once
  // with a zero result. In MEASURE the edge seen on the last window cycle is
  // folded into the latched count, so the result uses acc_nxt rather than acc.
  // Saturation sets the flag only when an edge arrives with acc already full.
  always_comb begin
    state_nxt    = state;
    gate_cnt_nxt = gate_cnt;
    acc_nxt      = acc;
    ovf_flag_nxt = ovf_flag;
    count_nxt    = count;
    ovf_nxt      = ovf;
    done_nxt     = 1'b0;
`ifdef RO_FREQ_CONT_EN
    gate_lat_nxt = gate_lat;
`endif

    case (state)
      S_IDLE, S_DONE: begin
        if (start_rise) begin
          if (gate_len != '0) begin
            state_nxt    = S_MEASURE;
            gate_cnt_nxt = gate_len;
            acc_nxt      = '0;
            ovf_flag_nxt = 1'b0;
          end else begin
            state_nxt = S_DONE;
            count_nxt = '0;
            ovf_nxt   = 1'b0;
            done_nxt  = 1'b1;
          end
`ifdef RO_FREQ_CONT_EN
          gate_lat_nxt = gate_len;
`endif
        end
`ifdef RO_FREQ_CONT_EN
        else if ((state == S_DONE) && start && (gate_lat != '0)) begin
          state_nxt    = S_MEASURE;
          gate_cnt_nxt = gate_lat;
          acc_nxt      = '0;
          ovf_flag_nxt = 1'b0;
        end
`endif
      end

      S_MEASURE: begin
        gate_cnt_nxt = gate_cnt - GATE_W'(1);
        if (ro_edge) begin
          if (&acc) begin
            ovf_flag_nxt = 1'b1;
          end else begin
            acc_nxt = acc + CNT_W'(1);
          end
        end
        if (gate_cnt == GATE_W'(1)) begin
          state_nxt = S_DONE;
          count_nxt = acc_nxt;
          ovf_nxt   = ovf_flag_nxt;
          done_nxt  = 1'b1;
        end
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  assign busy = (state == S_MEASURE);

  // Widen or trim count to 16 bits so the byte mux is the same for any CNT_W.
  logic [15:0] count_ext;

  generate
    if (CNT_W >= 16) begin : g_count_wide
      assign count_ext = count[15:0];
    end else begin : g_count_narrow
      assign count_ext = {{(16-CNT_W){1'b0}}, count};
    end
  endgenerate

  assign count_byte = byte_sel ? count_ext[15:8] : count_ext[7:0];

endmodule

// File: tb/tb_ro_freq_meter.sv
// tb_ro_freq_meter
//
// Drives ro_freq_meter with periodic and random ring-oscillator patterns and
// predicts each result by counting rising edges of the sampled input history
// over the measurement window, shifted by the synchroniser latency. Two
// instances run side by side: the default widths and a 4-bit counter that
// exercises saturation. Continuous-mode checks are built when
// RO_FREQ_CONT_EN is defined.

module tb_ro_freq_meter;

  localparam int SYNC = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        ro_in = 1'b0;
  logic        start = 1'b0;
  logic        byte_sel = 1'b0;
  logic [15:0] gate_len = 16'd0;

  logic        busy0, done0, ovf0;
  logic [15:0] count0;
  logic [7:0]  byte0;
  logic        busy4, done4, ovf4;
  logic [3:0]  count4;
  logic [7:0]  byte4;

  int checks = 0;
  int errors = 0;

  int ro_mode   = 0;
  int ro_period = 8;
  int ro_phase  = 0;
  bit ro_hist[$];

  ro_freq_meter dut (
    .clk(clk), .rst_n(rst_n), .ro_in(ro_in), .start(start),
    .gate_len(gate_len), .byte_sel(byte_sel), .busy(busy0), .done(done0),
    .ovf(ovf0), .count(count0), .count_byte(byte0)
  );

  ro_freq_meter #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .ro_in(ro_in), .start(start),
    .gate_len(gate_len), .byte_sel(byte_sel), .busy(busy4), .done(done4),
    .ovf(ovf4), .count(count4), .count_byte(byte4)
  );

  always #5 clk = ~clk;

  // Ring-oscillator source: 0 = held low, 1 = square wave, 2 = random bits.
  always @(negedge clk) begin
    if (ro_mode == 1) begin
      ro_in = (ro_phase < ro_period / 2);
      ro_phase = (ro_phase + 1) % ro_period;
    end else if (ro_mode == 2) begin
      ro_in = 1'($urandom_range(0, 1));
    end else begin
      ro_in = 1'b0;
    end
  end

  // Value of ro_in at every rising clock edge; index = edge number.
  always @(posedge clk) ro_hist.push_back(ro_in);

  function automatic int count_rises(int lo, int hi);
    int n = 0;
    for (int j = lo; j <= hi; j++) begin
      if (j >= 1 && j < ro_hist.size() && ro_hist[j] && !ro_hist[j-1]) n++;
    end
    return n;
  endfunction

  function automatic void set_square(int period);
    ro_mode = 1;
    ro_period = period;
    ro_phase = 0;
  endfunction

  task automatic launch(input int len, output int a_idx);
    @(negedge clk);
    gate_len = 16'(len);
    start = 1'b1;
    a_idx = ro_hist.size();
  endtask

  // Follows one window from the edge after acceptance to the done pulse and
  // checks busy length, result, overflow and both bytes against the model.
  task automatic wait_result(input string name, input bit use4, input int a_idx,
                             input int len, input bit hold, input bit disturb,
                             input bit tail, output int done_at);
    int busy_cyc = 0;
    bit seen = 0;
    int edges, maxv, exp_cnt;
    bit exp_ovf;
    logic b, d, o;
    logic [15:0] cnt_act;
    logic [7:0] cb, cb_exp;
    done_at = -1;
    for (int c = 0; c < len + 20 && !seen; c++) begin
      @(negedge clk);
      if (!hold && c == 0) start = 1'b0;
      if (disturb && c == len / 2) begin
        start = 1'b1;
        gate_len = 16'd7;
      end
      if (disturb && c == len / 2 + 1) start = 1'b0;
      d = use4 ? done4 : done0;
      b = use4 ? busy4 : busy0;
      if (d === 1'b1) begin
        seen = 1;
        done_at = ro_hist.size();
      end else if (b === 1'b1) begin
        busy_cyc++;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("[TB] FAIL %s done_timeout: no done within %0d cycles", name, len + 20);
      return;
    end
    checks++;
    if (busy_cyc !== len) begin
      errors++;
      $display("[TB] FAIL %s busy_cycles: got %0d expected %0d", name, busy_cyc, len);
    end
    edges   = count_rises(a_idx + 1 - SYNC, a_idx + len - SYNC);
    maxv    = use4 ? 15 : 65535;
    exp_cnt = (edges > maxv) ? maxv : edges;
    exp_ovf = (edges > maxv);
    cnt_act = use4 ? {12'd0, count4} : count0;
    o       = use4 ? ovf4 : ovf0;
    checks++;
    if (cnt_act !== 16'(exp_cnt)) begin
      errors++;
      $display("[TB] FAIL %s count: got %0d expected %0d", name, cnt_act, exp_cnt);
    end
    checks++;
    if (o !== exp_ovf) begin
      errors++;
      $display("[TB] FAIL %s ovf: got %b expected %b", name, o, exp_ovf);
    end
    for (int sel = 0; sel < 2; sel++) begin
      byte_sel = sel[0];
      #1;
      cb = use4 ? byte4 : byte0;
      cb_exp = 8'((exp_cnt >> (8 * sel)) & 255);
      checks++;
      if (cb !== cb_exp) begin
        errors++;
        $display("[TB] FAIL %s count_byte[%0d]: got %h expected %h", name, sel, cb, cb_exp);
      end
    end
    if (tail) begin
      @(negedge clk);
      d = use4 ? done4 : done0;
      b = use4 ? busy4 : busy0;
      checks++;
      if (d !== 1'b0 || b !== 1'b0) begin
        errors++;
        $display("[TB] FAIL %s after_done: got done=%b busy=%b expected 0/0", name, d, b);
      end
    end
  endtask

  task automatic test_reset;
    int active = 0;
    set_square(6);
    #1 rst_n = 1'b0;
    repeat (6) @(negedge clk);
    checks++;
    if ({busy0, done0, ovf0, count0, byte0} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_dut16: got busy=%b done=%b ovf=%b count=%h byte=%h expected all 0",
               busy0, done0, ovf0, count0, byte0);
    end
    checks++;
    if ({busy4, done4, ovf4, count4, byte4} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_dut4: got busy=%b done=%b ovf=%b count=%h byte=%h expected all 0",
               busy4, done4, ovf4, count4, byte4);
    end
    rst_n = 1'b1;
    repeat (30) begin
      @(negedge clk);
      if (busy0 || done0 || busy4 || done4 || count0 != 0 || count4 != 0) active++;
    end
    checks++;
    if (active !== 0) begin
      errors++;
      $display("[TB] FAIL idle_no_start: got %0d active cycles expected 0", active);
    end
  endtask

  task automatic test_basic;
    int a, d;
    set_square(8);
    repeat (20) @(negedge clk);
    launch(80, a);
    wait_result("basic_p8_g80", 0, a, 80, 0, 0, 1, d);
  endtask

  task automatic test_saturate;
    int a, d;
    set_square(4);
    repeat (10) @(negedge clk);
    launch(100, a);
    wait_result("sat4_g100", 1, a, 100, 0, 0, 1, d);
    launch(20, a);
    wait_result("sat4_g20", 1, a, 20, 0, 0, 1, d);
  endtask

  task automatic test_zero_len;
    int a, d;
    launch(0, a);
    wait_result("zero_len", 0, a, 0, 0, 0, 1, d);
  endtask

  task automatic test_long_window;
    int a, d;
    set_square(2);
    repeat (6) @(negedge clk);
    launch(9320, a);
    wait_result("long_g9320", 0, a, 9320, 0, 1, 1, d);
  endtask

  task automatic test_abort;
    int a;
    set_square(8);
    launch(300, a);
    @(negedge clk);
    start = 1'b0;
    repeat (100) @(negedge clk);
    checks++;
    if (busy0 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL abort_pre_busy: got %b expected 1", busy0);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy0, done0, ovf0, count0, byte0} !== '0) begin
      errors++;
      $display("[TB] FAIL abort_outputs: got busy=%b done=%b ovf=%b count=%h byte=%h expected all 0",
               busy0, done0, ovf0, count0, byte0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    checks++;
    if (busy0 !== 1'b0 || count0 !== 16'd0) begin
      errors++;
      $display("[TB] FAIL abort_idle: got busy=%b count=%h expected 0/0", busy0, count0);
    end
  endtask

  task automatic test_random;
    int a, d, len;
    bit use4;
    for (int k = 0; k < 8; k++) begin
      if ($urandom_range(0, 1) == 1) begin
        set_square(2 * $urandom_range(1, 6));
      end else begin
        ro_mode = 2;
      end
      repeat ($urandom_range(5, 12)) @(negedge clk);
      len = (k == 0) ? 1 : $urandom_range(2, 300);
      use4 = k[0];
      launch(len, a);
      wait_result($sformatf("rand%0d_g%0d_w%0d", k, len, use4 ? 4 : 16), use4, a, len, 0, 0, 1, d);
    end
  endtask

`ifdef RO_FREQ_CONT_EN
  task automatic test_continuous;
    int a, d, prev_d, idle_busy;
    set_square(8);
    repeat (10) @(negedge clk);
    launch(40, a);
    prev_d = -1;
    for (int k = 0; k < 3; k++) begin
      wait_result($sformatf("cont%0d", k), 0, a + 41 * k, 40, 1, 0, 0, d);
      if (k > 0) begin
        checks++;
        if (d - prev_d !== 41) begin
          errors++;
          $display("[TB] FAIL cont_period%0d: got %0d expected 41", k, d - prev_d);
        end
      end
      prev_d = d;
    end
    start = 1'b0;
    idle_busy = 0;
    repeat (30) begin
      @(negedge clk);
      if (busy0 || done0) idle_busy++;
    end
    checks++;
    if (idle_busy !== 0) begin
      errors++;
      $display("[TB] FAIL cont_stop: got %0d active cycles expected 0", idle_busy);
    end
  endtask
`else
  task automatic test_start_held;
    int a, d, idle_busy;
    set_square(8);
    repeat (10) @(negedge clk);
    launch(30, a);
    wait_result("held", 0, a, 30, 1, 0, 1, d);
    idle_busy = 0;
    repeat (40) begin
      @(negedge clk);
      if (busy0 || done0) idle_busy++;
    end
    checks++;
    if (idle_busy !== 0) begin
      errors++;
      $display("[TB] FAIL held_no_rearm: got %0d active cycles expected 0", idle_busy);
    end
    start = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_saturate();
    test_zero_len();
    test_long_window();
    test_abort();
    test_random();
`ifdef RO_FREQ_CONT_EN
    test_continuous();
`else
    test_start_held();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
